// File: rtl/multich_pingpong_pkg.sv
// Shared types and register map for the multi-channel ping-pong capture buffer.
package multich_pingpong_pkg;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ARMED = 2'd1,
        W_FILL  = 2'd2,
        W_FULL  = 2'd3
    } w_state_e;

    typedef enum logic [1:0] {
        MODE_FREE = 2'd0,
        MODE_RISE = 2'd1,
        MODE_FALL = 2'd2,
        MODE_RSVD = 2'd3
    } trig_mode_e;

    // Register offsets from CTRL_BASE
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_LOCK    = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_OVERRUN = 2'd3;

    // STATUS bit positions; writer state occupies ST_STATE +: 2
    localparam int ST_READY = 0;
    localparam int ST_RBANK = 1;
    localparam int ST_LOCK  = 2;
    localparam int ST_STATE = 3;

endpackage

// File: rtl/capture_bank_ram.sv
// One capture bank: all channels of one sample index per word, registered read.
module capture_bank_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port plus read register; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/multich_pingpong_buffer.sv
// Multi-channel ADC ping-pong capture buffer with trigger modes, host lock and
// a small status/control register block on the FSMC-style bus.
//
// state   | meaning
// --------+----------------------------------------------------------
// W_IDLE  | waiting for stable; picks free-run fill or armed wait
// W_ARMED | waiting for the selected trig_in edge
// W_FILL  | storing one word per adc_valid into write_bank
// W_FULL  | bank complete; swap when unlocked, else drop and count
module multich_pingpong_buffer
    import multich_pingpong_pkg::*;
#(
    parameter int          DATA_WIDTH   = 12,
    parameter int          NUM_CH       = 2,
    parameter int          DEPTH        = 1024,
    parameter int          BUS_WIDTH    = 16,
    parameter logic [15:0] CTRL_BASE    = 16'h4000,
    parameter int          DEFAULT_MODE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         adc_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] adc_data,
    input  logic                         stable,
    input  logic                         trig_in,
    input  logic                         bus_en,
    input  logic                         bus_we,
    input  logic [15:0]                  bus_addr,
    input  logic [BUS_WIDTH-1:0]         bus_wdata,
    output logic [BUS_WIDTH-1:0]         bus_rdata,
    output logic                         bus_rvalid,
    output logic                         ready,
    output logic                         write_bank
);

    localparam int AW   = $clog2(DEPTH);
    localparam int WW   = NUM_CH * DATA_WIDTH;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    w_state_e          w_state;
    trig_mode_e        mode, armed_mode;
    logic [AW-1:0]     wr_ptr;
    logic              trig_q, lock;
    logic [15:0]       overrun;

    logic [15:0]       ch_num, reg_off;
    logic              is_mem, ch_ok, is_reg, rd_req, wr_reg;
    logic              lock_set, swap, ovr_inc, do_write, trig_rise, trig_fall;
    logic [BUS_WIDTH-1:0] reg_rd, reg_q;
    logic              mem_sel_q, rd_bank_q;
    logic [CH_W-1:0]   rd_ch_q;
    logic [WW-1:0]     rdata0, rdata1, word;
    logic [DATA_WIDTH-1:0] sample;
    logic              unused_wdata;

    assign unused_wdata = ^bus_wdata[BUS_WIDTH-1:2];

    assign is_mem  = bus_addr < CTRL_BASE;
    assign ch_num  = bus_addr >> AW;
    assign ch_ok   = is_mem && (int'(ch_num) < NUM_CH);
    assign reg_off = bus_addr - CTRL_BASE;
    assign is_reg  = !is_mem && (reg_off[15:2] == '0);
    assign rd_req  = bus_en && !bus_we;
    assign wr_reg  = bus_en && bus_we && is_reg;

    assign trig_rise = trig_in && !trig_q;
    assign trig_fall = !trig_in && trig_q;

    // A LOCK=1 write in the swap cycle suppresses the swap.
    assign lock_set = wr_reg && (reg_off[1:0] == REG_LOCK) && bus_wdata[0];
    assign swap     = (w_state == W_FULL) && stable && !lock && !lock_set;
    assign do_write = (w_state == W_FILL) && stable && adc_valid;
    assign ovr_inc  = ((w_state == W_FULL) && stable && lock && adc_valid) || (swap && ready);

    capture_bank_ram #(.DEPTH(DEPTH), .WIDTH(WW)) u_bank0 (
        .clk(clk), .we(do_write && !write_bank), .waddr(wr_ptr), .wdata(adc_data),
        .re(rd_req && ch_ok), .raddr(bus_addr[AW-1:0]), .rdata(rdata0)
    );

    capture_bank_ram #(.DEPTH(DEPTH), .WIDTH(WW)) u_bank1 (
        .clk(clk), .we(do_write && write_bank), .waddr(wr_ptr), .wdata(adc_data),
        .re(rd_req && ch_ok), .raddr(bus_addr[AW-1:0]), .rdata(rdata1)
    );

    // Writer FSM: fill, swap and abort handling; ready/write_bank are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            wr_ptr     <= '0;
            write_bank <= 1'b0;
            ready      <= 1'b0;
            armed_mode <= MODE_FREE;
            trig_q     <= 1'b0;
        end else begin
            trig_q <= trig_in;
            if (lock_set) ready <= 1'b0;
            if (!stable) begin
                w_state <= W_IDLE;
                wr_ptr  <= '0;
            end else begin
                case (w_state)
                    W_IDLE: begin
                        armed_mode <= mode;
                        w_state    <= (mode == MODE_RISE || mode == MODE_FALL) ? W_ARMED : W_FILL;
                    end
                    W_ARMED: begin
                        if ((armed_mode == MODE_RISE && trig_rise) ||
                            (armed_mode == MODE_FALL && trig_fall))
                            w_state <= W_FILL;
                    end
                    W_FILL: begin
                        if (adc_valid) begin
                            wr_ptr <= wr_ptr + AW'(1);
                            if (wr_ptr == '1) w_state <= W_FULL;
                        end
                    end
                    W_FULL: begin
                        if (swap) begin
                            write_bank <= ~write_bank;
                            ready      <= 1'b1;
                            wr_ptr     <= '0;
                            w_state    <= W_IDLE;
                        end
                    end
                    default: w_state <= W_IDLE;
                endcase
            end
        end
    end

    // Host-writable control registers and the saturating overrun counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock    <= 1'b0;
            mode    <= trig_mode_e'(DEFAULT_MODE[1:0]);
            overrun <= '0;
        end else begin
            if (wr_reg && reg_off[1:0] == REG_LOCK) lock <= bus_wdata[0];
            if (wr_reg && reg_off[1:0] == REG_MODE) mode <= trig_mode_e'(bus_wdata[1:0]);
            if (wr_reg && reg_off[1:0] == REG_OVERRUN) overrun <= '0;
            else if (ovr_inc && overrun != 16'hFFFF) overrun <= overrun + 16'd1;
        end
    end

    // Register read value; zero for memory space and unmapped addresses.
    always_comb begin
        reg_rd = '0;
        if (is_reg) begin
            case (reg_off[1:0])
                REG_STATUS: begin
                    reg_rd[ST_READY]      = ready;
                    reg_rd[ST_RBANK]      = ~write_bank;
                    reg_rd[ST_LOCK]       = lock;
                    reg_rd[ST_STATE +: 2] = w_state;
                end
                REG_LOCK: reg_rd[0]   = lock;
                REG_MODE: reg_rd[1:0] = mode;
                default:  reg_rd      = BUS_WIDTH'(overrun);
            endcase
        end
    end

    // Read pipeline: capture the source select alongside the RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rvalid <= 1'b0;
            mem_sel_q  <= 1'b0;
            reg_q      <= '0;
            rd_bank_q  <= 1'b0;
            rd_ch_q    <= '0;
        end else begin
            bus_rvalid <= rd_req;
            if (rd_req) begin
                mem_sel_q <= ch_ok;
                reg_q     <= reg_rd;
                rd_bank_q <= ~write_bank;
                rd_ch_q   <= ch_num[CH_W-1:0];
            end
        end
    end

    // Channel slice of the read-bank word, zero-extended onto the bus.
    always_comb begin
        sample = '0;
        word   = rd_bank_q ? rdata1 : rdata0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_q == c[CH_W-1:0]) sample = word[c*DATA_WIDTH +: DATA_WIDTH];
        end
        bus_rdata = mem_sel_q ? BUS_WIDTH'(sample) : reg_q;
    end

endmodule

// File: tb/tb_multich_pingpong_buffer.sv
// Directed bench for multich_pingpong_buffer with a read-data scoreboard.
module tb_multich_pingpong_buffer;

    localparam int          DW  = 12;
    localparam int          NCH = 2;
    localparam int          DEP = 16;
    localparam int          BW  = 16;
    localparam logic [15:0] CB  = 16'h4000;
    localparam logic [15:0] A_STATUS  = CB + 16'd0;
    localparam logic [15:0] A_LOCK    = CB + 16'd1;
    localparam logic [15:0] A_MODE    = CB + 16'd2;
    localparam logic [15:0] A_OVERRUN = CB + 16'd3;

    logic              clk = 1'b0;
    logic              rst, adc_valid, stable, trig_in, bus_en, bus_we;
    logic [NCH*DW-1:0] adc_data;
    logic [15:0]       bus_addr;
    logic [BW-1:0]     bus_wdata, bus_rdata;
    logic              bus_rvalid, ready, write_bank;

    always #5 clk = ~clk;

    multich_pingpong_buffer #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP), .BUS_WIDTH(BW),
        .CTRL_BASE(CB), .DEFAULT_MODE(1)
    ) dut (
        .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .stable(stable), .trig_in(trig_in), .bus_en(bus_en), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_rvalid(bus_rvalid), .ready(ready), .write_bank(write_bank)
    );

    typedef struct {
        logic [15:0] exp;
        logic [15:0] addr;
        int          cyc;
    } rd_exp_t;

    rd_exp_t q[$];
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every rvalid pops one expected read and checks data and latency.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (bus_rvalid === 1'b1) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL rvalid_unexpected: got rvalid=1, expected no read pending (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("rdata@%04h", e.addr), 32'(bus_rdata), 32'(e.exp));
                    chk($sformatf("rlat@%04h", e.addr), cyc, e.cyc + 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] e);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
        q.push_back('{e, a, cyc});
        @(negedge clk);
        bus_en = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_en = 1'b0; bus_we = 1'b0;
    endtask

    task automatic strobe(input int c0, input int c1);
        adc_valid = 1'b1;
        adc_data  = {DW'(c1), DW'(c0)};
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; adc_valid = 1'b0; adc_data = '0; stable = 1'b0; trig_in = 1'b0;
        bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        tick(3);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_wbank", 32'(write_bank), 0);
        chk("rst_rvalid", 32'(bus_rvalid), 0);
        chk("rst_rdata", 32'(bus_rdata), 0);
        rst = 1'b0;
        tick(1);

        // Free-run capture into bank 0
        bus_write(A_MODE, 16'd0);
        stable = 1'b1;
        tick(2);
        for (int i = 0; i < DEP; i++) strobe(i, 100 + i);
        tick(3);
        chk("free_ready", 32'(ready), 1);
        chk("free_wbank", 32'(write_bank), 1);
        for (int i = 0; i < DEP; i++) bus_read(16'(i), 16'(i));
        for (int i = 0; i < DEP; i++) bus_read(16'(DEP + i), 16'(100 + i));
        bus_read(A_STATUS, 16'h0011);

        // Rising-edge trigger into bank 1; pre-edge and edge-cycle samples are dropped
        stable = 1'b0;
        tick(1);
        bus_write(A_MODE, 16'd1);
        stable = 1'b1;
        tick(2);
        bus_read(A_STATUS, 16'h0009);
        for (int i = 0; i < 7; i++) strobe(200 + i, 200 + i);
        trig_in = 1'b1;
        strobe(99, 99);
        for (int i = 0; i < DEP; i++) strobe(20 + i, 12'h800 + i);
        tick(3);
        chk("trig_wbank", 32'(write_bank), 0);
        chk("trig_ready", 32'(ready), 1);
        bus_read(A_OVERRUN, 16'd1);
        for (int i = 0; i < DEP; i++) bus_read(16'(i), 16'(20 + i));
        for (int i = 0; i < DEP; i++) bus_read(16'(DEP + i), 16'(12'h800 + i));
        bus_write(A_OVERRUN, 16'hFFFF);
        bus_read(A_OVERRUN, 16'd0);

        // Lock: second bank fills, extra samples counted, swap after release
        bus_write(A_LOCK, 16'd1);
        chk("lock_ready_clr", 32'(ready), 0);
        bus_read(A_LOCK, 16'd1);
        trig_in = 1'b0;
        tick(1);
        trig_in = 1'b1;
        tick(1);
        for (int i = 0; i < DEP; i++) strobe(500 + i, 600 + i);
        for (int i = 0; i < 5; i++) strobe(900, 900);
        chk("lock_wbank_hold", 32'(write_bank), 0);
        chk("lock_ready_hold", 32'(ready), 0);
        bus_read(A_OVERRUN, 16'd5);
        bus_read(A_STATUS, 16'h001E);
        bus_write(A_LOCK, 16'd0);
        tick(1);
        chk("unlock_wbank", 32'(write_bank), 1);
        chk("unlock_ready", 32'(ready), 1);
        bus_read(A_OVERRUN, 16'd5);
        bus_read(16'd3, 16'd503);
        bus_read(16'd19, 16'd603);
        bus_write(A_OVERRUN, 16'd0);
        bus_read(A_OVERRUN, 16'd0);

        // Abort at wr_ptr=9, then restart in free-run from index 0
        trig_in = 1'b0;
        tick(1);
        trig_in = 1'b1;
        tick(1);
        for (int i = 0; i < 9; i++) strobe(700 + i, 700 + i);
        stable = 1'b0;
        tick(1);
        chk("abort_wbank", 32'(write_bank), 1);
        chk("abort_ready", 32'(ready), 1);
        bus_read(A_STATUS, 16'h0001);
        bus_write(A_MODE, 16'd0);
        stable = 1'b1;
        tick(2);
        for (int i = 0; i < DEP; i++) strobe(40 + i, 60 + i);
        tick(3);
        chk("restart_wbank", 32'(write_bank), 0);
        chk("restart_ready", 32'(ready), 1);
        bus_read(A_OVERRUN, 16'd1);
        bus_read(16'd0, 16'd40);
        bus_read(16'd9, 16'd49);
        bus_read(16'd15, 16'd55);
        bus_read(16'd25, 16'd69);

        // Unmapped reads, ignored memory write, LOCK=1 in the swap cycle
        bus_read(16'd32, 16'd0);
        bus_read(CB + 16'd4, 16'd0);
        bus_write(16'd0, 16'h0ABC);
        bus_read(16'd0, 16'd40);
        for (int i = 0; i < DEP; i++) strobe(1 + i, 2 + i);
        bus_write(A_LOCK, 16'd1);
        chk("simul_wbank", 32'(write_bank), 0);
        chk("simul_ready", 32'(ready), 0);
        bus_read(A_STATUS, 16'h001E);
        bus_read(A_OVERRUN, 16'd1);
        bus_write(A_LOCK, 16'd0);
        tick(1);
        chk("simul_release_wbank", 32'(write_bank), 1);
        bus_read(16'd5, 16'd6);
        bus_read(A_OVERRUN, 16'd1);

        // Reset in the middle of a fill
        tick(2);
        for (int i = 0; i < 5; i++) strobe(800 + i, 800 + i);
        tick(2);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready), 0);
        chk("mid_rst_wbank", 32'(write_bank), 0);
        chk("mid_rst_rvalid", 32'(bus_rvalid), 0);
        chk("mid_rst_rdata", 32'(bus_rdata), 0);
        stable = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        // Read bank is the complement of write_bank (0), so only bit1 is set.
        bus_read(A_STATUS, 16'h0002);
        bus_read(A_MODE, 16'd1);
        bus_read(A_OVERRUN, 16'd0);
        bus_read(A_LOCK, 16'd0);

        tick(4);
        while (q.size() > 0) begin
            rd_exp_t e;
            e = q.pop_front();
            n_total++;
            $display("FAIL rvalid_missing@%04h: got no rvalid, expected data %0h", e.addr, e.exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
